// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions: opcode values, FSM state encoding, op classes and
// the Moore strobe decode used by the multicycle controller.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_ZERO   = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OPC_NONE   = 3'd0,
    OPC_R      = 3'd1,
    OPC_I      = 3'd2,
    OPC_BRANCH = 3'd3,
    OPC_LOAD   = 3'd4,
    OPC_STORE  = 3'd5
  } op_class_e;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic mem_read_en;
    logic dm_write_en;
    logic rf_write_en;
    logic finished;
  } strobes_t;

  function automatic logic is_mem_class(op_class_e cls);
    return (cls == OPC_LOAD) || (cls == OPC_STORE);
  endfunction

  // Strobes depend only on state and the latched class, never on live inputs.
  function automatic strobes_t decode_strobes(state_e st, op_class_e cls);
    strobes_t s;
    s = '0;
    case (st)
      ST_FETCH:     s.fetch = 1'b1;
      ST_DECODE:    s.decode = 1'b1;
      ST_MEM: begin
        s.mem_read_en = (cls == OPC_LOAD);
        s.dm_write_en = (cls == OPC_STORE);
      end
      ST_WRITEBACK: begin
        s.finished    = 1'b1;
        s.rf_write_en = (cls == OPC_R) || (cls == OPC_I) || (cls == OPC_LOAD);
      end
      default:      s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_classifier.sv
// Combinational opcode classifier: maps instr[6:0] to an op class plus
// halt / illegal indications for the DECODE state.
module opcode_classifier
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output logic       is_halt,
  output logic       is_illegal
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    op_class   = OPC_NONE;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_R:               op_class = OPC_R;
      OP_I:               op_class = OPC_I;
      OP_BRANCH:          op_class = OPC_BRANCH;
      OP_LOAD:            op_class = OPC_LOAD;
      OP_STORE:           op_class = OPC_STORE;
      OP_SYSTEM, OP_ZERO: is_halt  = 1'b1;
      default:            is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/mem/writeback, handles
// memory handshakes with timeout, halts on SYSTEM/zero/illegal and counts retires.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int WORDSIZE    = 64,
  parameter int CNT_WIDTH   = WORDSIZE,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  output logic                 fetch,
  output logic                 decode,
  output logic                 dm_write_en,
  output logic                 mem_read_en,
  output logic                 rf_write_en,
  output logic                 finished,
  output logic                 halted,
  output logic                 illegal_instr,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [2:0]           state_dbg
);

  localparam int              TO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e               state_q, state_d;
  op_class_e            op_class_q, op_class_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  strobes_t             strobes_q, strobes_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;
  logic                 bus_err_q, bus_err_d;

  op_class_e dec_class;
  logic      dec_halt;
  logic      dec_illegal;

  opcode_classifier u_classifier (
    .opcode     (opcode),
    .op_class   (dec_class),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  always_comb begin
    state_d    = state_q;
    op_class_d = op_class_q;
    cnt_d      = cnt_q;
    instret_d  = instret_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        op_class_d = dec_class;
        if (dec_halt || dec_illegal) begin
          state_d   = ST_HALT;
          illegal_d = illegal_q | dec_illegal;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        cnt_d   = '0;
        state_d = is_mem_class(op_class_q) ? ST_MEM : ST_WRITEBACK;
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = ST_WRITEBACK;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_HALT;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_WRITEBACK: begin
        instret_d = instret_q + CNT_WIDTH'(1);
        state_d   = ST_FETCH;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    strobes_d = decode_strobes(state_d, op_class_d);
    halted_d  = (state_d == ST_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_class_q <= OPC_NONE;
      cnt_q      <= '0;
      instret_q  <= '0;
      strobes_q  <= '0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_class_q <= op_class_d;
      cnt_q      <= cnt_d;
      instret_q  <= instret_d;
      strobes_q  <= strobes_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign fetch         = strobes_q.fetch;
  assign decode        = strobes_q.decode;
  assign mem_read_en   = strobes_q.mem_read_en;
  assign dm_write_en   = strobes_q.dm_write_en;
  assign rf_write_en   = strobes_q.rf_write_en;
  assign finished      = strobes_q.finished;
  assign halted        = halted_q;
  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;
  assign instret       = instret_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequencing, memory waits,
// halts, bus timeout, async reset and instret wrap on a 4-bit counter instance.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, mem_ready;
  logic [6:0]  opcode;
  logic        fetch, decode, dm_write_en, mem_read_en, rf_write_en, finished;
  logic        halted, illegal_instr, bus_error;
  logic [63:0] instret;
  logic [2:0]  state_dbg;

  logic        rst_w, start_w;
  logic [6:0]  opcode_w;
  logic        fetch_w, decode_w, dm_write_en_w, mem_read_en_w, rf_write_en_w, finished_w;
  logic        halted_w, illegal_instr_w, bus_error_w;
  logic [3:0]  instret_w;
  logic [2:0]  state_dbg_w;

  int checks = 0;
  int errors = 0;

  // Strobe patterns: {fetch, decode, mem_read_en, dm_write_en, rf_write_en, finished}
  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_FETCH = 6'b100000;
  localparam logic [5:0] S_DEC   = 6'b010000;
  localparam logic [5:0] S_RD    = 6'b001000;
  localparam logic [5:0] S_WR    = 6'b000100;
  localparam logic [5:0] S_WB_RF = 6'b000011;
  localparam logic [5:0] S_WB    = 6'b000001;

  // Flag patterns: {halted, illegal_instr, bus_error}
  logic [11:0] obs;
  assign obs = {state_dbg, fetch, decode, mem_read_en, dm_write_en, rf_write_en, finished,
                halted, illegal_instr, bus_error};

  multicycle_control dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
    .fetch(fetch), .decode(decode), .dm_write_en(dm_write_en), .mem_read_en(mem_read_en),
    .rf_write_en(rf_write_en), .finished(finished), .halted(halted),
    .illegal_instr(illegal_instr), .bus_error(bus_error), .instret(instret),
    .state_dbg(state_dbg)
  );

  multicycle_control #(.CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst_w), .start(start_w), .opcode(opcode_w), .mem_ready(1'b0),
    .fetch(fetch_w), .decode(decode_w), .dm_write_en(dm_write_en_w),
    .mem_read_en(mem_read_en_w), .rf_write_en(rf_write_en_w), .finished(finished_w),
    .halted(halted_w), .illegal_instr(illegal_instr_w), .bus_error(bus_error_w),
    .instret(instret_w), .state_dbg(state_dbg_w)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ex(state_e s, logic [5:0] strb, logic [2:0] fl);
    return {s, strb, fl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = OP_R; mem_ready = 1'b0;
    rst_w = 1'b1; start_w = 1'b0; opcode_w = OP_R;
    tick(); tick();
    checks++;
    if (obs !== ex(ST_IDLE, S_NONE, 3'b000) || instret !== 64'd0) begin
      errors++; $display("FAIL reset_state: obs=%b instret=%0d want %b/0", obs, instret, ex(ST_IDLE, S_NONE, 3'b000));
    end
    rst = 1'b0; rst_w = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== ex(ST_IDLE, S_NONE, 3'b000)) begin
      errors++; $display("FAIL idle_no_start: obs=%b want %b", obs, ex(ST_IDLE, S_NONE, 3'b000));
    end
  endtask

  task automatic test_r_type();
    start = 1'b1; opcode = OP_R;
    tick();
    checks++;
    if (obs !== ex(ST_FETCH, S_FETCH, 3'b000)) begin
      errors++; $display("FAIL r_fetch: obs=%b want %b", obs, ex(ST_FETCH, S_FETCH, 3'b000));
    end
    start = 1'b0;
    tick();
    checks++;
    if (obs !== ex(ST_DECODE, S_DEC, 3'b000)) begin
      errors++; $display("FAIL r_decode: obs=%b want %b", obs, ex(ST_DECODE, S_DEC, 3'b000));
    end
    tick();
    checks++;
    if (obs !== ex(ST_EXECUTE, S_NONE, 3'b000)) begin
      errors++; $display("FAIL r_execute: obs=%b want %b", obs, ex(ST_EXECUTE, S_NONE, 3'b000));
    end
    tick();
    checks++;
    if (obs !== ex(ST_WRITEBACK, S_WB_RF, 3'b000)) begin
      errors++; $display("FAIL r_writeback: obs=%b want %b", obs, ex(ST_WRITEBACK, S_WB_RF, 3'b000));
    end
    opcode = OP_LOAD;
    tick();
    checks++;
    if (obs !== ex(ST_FETCH, S_FETCH, 3'b000) || instret !== 64'd1) begin
      errors++; $display("FAIL r_retire: obs=%b instret=%0d want %b/1", obs, instret, ex(ST_FETCH, S_FETCH, 3'b000));
    end
  endtask

  // Entered in FETCH with opcode=LOAD; ready arrives in the third MEM cycle.
  task automatic test_load_wait();
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== ex(ST_MEM, S_RD, 3'b000)) begin
        errors++; $display("FAIL load_mem%0d: obs=%b want %b", i, obs, ex(ST_MEM, S_RD, 3'b000));
      end
      if (i == 2) mem_ready = 1'b1;
    end
    tick();
    checks++;
    if (obs !== ex(ST_WRITEBACK, S_WB_RF, 3'b000)) begin
      errors++; $display("FAIL load_writeback: obs=%b want %b", obs, ex(ST_WRITEBACK, S_WB_RF, 3'b000));
    end
    mem_ready = 1'b0; opcode = OP_STORE;
    tick();
    checks++;
    if (instret !== 64'd2) begin
      errors++; $display("FAIL load_retire: instret=%0d want 2", instret);
    end
  endtask

  task automatic test_store_immediate();
    tick(); tick(); tick();
    checks++;
    if (obs !== ex(ST_MEM, S_WR, 3'b000)) begin
      errors++; $display("FAIL store_mem: obs=%b want %b", obs, ex(ST_MEM, S_WR, 3'b000));
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (obs !== ex(ST_WRITEBACK, S_WB, 3'b000)) begin
      errors++; $display("FAIL store_writeback: obs=%b want %b", obs, ex(ST_WRITEBACK, S_WB, 3'b000));
    end
    opcode = OP_BRANCH;
    tick();
    checks++;
    if (instret !== 64'd3) begin
      errors++; $display("FAIL store_retire: instret=%0d want 3", instret);
    end
  endtask

  // mem_ready stays high through the branch and must be ignored outside MEM.
  task automatic test_branch();
    tick();
    tick();
    checks++;
    if (obs !== ex(ST_EXECUTE, S_NONE, 3'b000)) begin
      errors++; $display("FAIL branch_execute: obs=%b want %b", obs, ex(ST_EXECUTE, S_NONE, 3'b000));
    end
    tick();
    checks++;
    if (obs !== ex(ST_WRITEBACK, S_WB, 3'b000)) begin
      errors++; $display("FAIL branch_writeback: obs=%b want %b", obs, ex(ST_WRITEBACK, S_WB, 3'b000));
    end
    mem_ready = 1'b0; opcode = 7'b1111111;
    tick();
    checks++;
    if (obs !== ex(ST_FETCH, S_FETCH, 3'b000) || instret !== 64'd4) begin
      errors++; $display("FAIL branch_retire: obs=%b instret=%0d want %b/4", obs, instret, ex(ST_FETCH, S_FETCH, 3'b000));
    end
  endtask

  task automatic test_illegal();
    tick();
    start = 1'b1;
    tick();
    checks++;
    if (obs !== ex(ST_HALT, S_NONE, 3'b110) || instret !== 64'd4) begin
      errors++; $display("FAIL illegal_halt: obs=%b instret=%0d want %b/4", obs, instret, ex(ST_HALT, S_NONE, 3'b110));
    end
    tick(); tick();
    checks++;
    if (obs !== ex(ST_HALT, S_NONE, 3'b110)) begin
      errors++; $display("FAIL halt_sticky: obs=%b want %b", obs, ex(ST_HALT, S_NONE, 3'b110));
    end
    start = 1'b0;
  endtask

  task automatic test_halt_opcodes();
    logic [6:0] ops [2];
    ops[0] = OP_SYSTEM;
    ops[1] = OP_ZERO;
    for (int k = 0; k < 2; k++) begin
      pulse_reset();
      opcode = ops[k]; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      checks++;
      if (obs !== ex(ST_HALT, S_NONE, 3'b100)) begin
        errors++; $display("FAIL halt_op_%0d: obs=%b want %b", k, obs, ex(ST_HALT, S_NONE, 3'b100));
      end
    end
  endtask

  task automatic test_bus_timeout();
    int mem_cycles;
    pulse_reset();
    opcode = OP_STORE; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    mem_cycles = 0;
    for (int i = 0; i < 40 && state_dbg !== 3'(ST_HALT); i++) begin
      tick();
      if (dm_write_en === 1'b1) mem_cycles++;
    end
    checks++;
    if (mem_cycles !== 16) begin
      errors++; $display("FAIL timeout_cycles: dm_write_en cycles=%0d want 16", mem_cycles);
    end
    checks++;
    if (obs !== ex(ST_HALT, S_NONE, 3'b101)) begin
      errors++; $display("FAIL timeout_halt: obs=%b want %b", obs, ex(ST_HALT, S_NONE, 3'b101));
    end
  endtask

  task automatic test_reset_mid_mem();
    pulse_reset();
    opcode = OP_R; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    opcode = OP_LOAD;
    tick(); tick(); tick(); tick();
    checks++;
    if (obs !== ex(ST_MEM, S_RD, 3'b000) || instret !== 64'd1) begin
      errors++; $display("FAIL pre_reset_mem: obs=%b instret=%0d want %b/1", obs, instret, ex(ST_MEM, S_RD, 3'b000));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== ex(ST_IDLE, S_NONE, 3'b000) || instret !== 64'd0) begin
      errors++; $display("FAIL async_reset: obs=%b instret=%0d want %b/0", obs, instret, ex(ST_IDLE, S_NONE, 3'b000));
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== ex(ST_IDLE, S_NONE, 3'b000)) begin
      errors++; $display("FAIL post_reset_idle: obs=%b want %b", obs, ex(ST_IDLE, S_NONE, 3'b000));
    end
  endtask

  task automatic test_instret_wrap();
    int n_fin;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    n_fin = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (finished_w === 1'b1) n_fin++;
    end
    checks++;
    if (instret_w !== 4'd15 || fetch_w !== 1'b1) begin
      errors++; $display("FAIL wrap_15: instret=%0d fetch=%b want 15/1", instret_w, fetch_w);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (finished_w === 1'b1) n_fin++;
    end
    checks++;
    if (instret_w !== 4'd0 || n_fin !== 16) begin
      errors++; $display("FAIL wrap_0: instret=%0d finished=%0d want 0/16", instret_w, n_fin);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_store_immediate();
    test_branch();
    test_illegal();
    test_halt_opcodes();
    test_bus_timeout();
    test_reset_mid_mem();
    test_instret_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
